alu_host_seq: RTL and testbench

ALU_HOST_SEQ -- requirements
Module: alu_host_seq

---
 rtl/alu_host_seq.sv | 219 +++++++++++++++++++++
 tb/tb_alu_host_seq.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_host_seq.sv
// -----------------------------------------------------------------------------
// alu_host_seq
//
// Host-side sequencer for a byte-serial ALU control unit. Commands {op, x, y}
// are buffered in a 2-entry FIFO, issued to the ALU as a start pulse followed
// by the two operand bytes, and the one or two result bytes are collected and
// returned as a 16-bit response.
//
// Optional feature: define ALU_TIMEOUT_EN to enable a 6-bit watchdog on the
// WAIT/CAP2 states. On expiry a response with rsp_err=1 and rsp_data=0 is
// returned. Without the macro the sequencer waits indefinitely and rsp_err
// is tied low.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once rsp_valid is high, rsp_data/rsp_op/rsp_err stay stable
// until the transfer. A command pushed into a full FIFO is still accepted in
// a cycle where the FIFO is also popped, because the pop frees the slot first.
//
// Ports:
//   clk, rst_b             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_x, cmd_y   00 add, 01 sub, 10 mul, 11 div; x dividend, y divisor
//   alu_start              one-cycle start pulse to the ALU
//   alu_s                  opcode to the ALU, holds the last issued opcode
//   alu_inbus              operand bus (x, then y, otherwise 0)
//   alu_finish/alu_outbus  ALU result-valid strobe and result byte
//   rsp_valid/rsp_ready    response handshake
//   rsp_data, rsp_op       result and its opcode
//                          (add/sub {00,byte}; mul {hi,lo}; div {rem,quot})
//   rsp_err                watchdog timeout flag
//   busy                   FSM not idle or FIFO non-empty
//   fsm_state              current FSM state: 0 IDLE, 1 ISSUE_X, 2 ISSUE_Y,
//                          3 WAIT, 4 CAP2, 5 RESP
// -----------------------------------------------------------------------------
module alu_host_seq (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  output logic        alu_start,
  output logic [1:0]  alu_s,
  output logic [7:0]  alu_inbus,
  input  logic        alu_finish,
  input  logic [7:0]  alu_outbus,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_X = 3'd1,
    S_ISSUE_Y = 3'd2,
    S_WAIT    = 3'd3,
    S_CAP2    = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------------
  // Command FIFO, 2 entries of {op, x, y}
  // ---------------------------------------------------------------------------
  logic [17:0] fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_count;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [17:0] fifo_head;

  assign fifo_full  = (fifo_count == 2'd2);
  assign fifo_empty = (fifo_count == 2'd0);
  assign fifo_pop   = (state == S_IDLE) && !fifo_empty;
  // The pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign fifo_push  = cmd_valid && (!fifo_full || fifo_pop);
  assign cmd_ready  = !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= {cmd_op, cmd_x, cmd_y};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (fifo_push) wr_ptr <= ~wr_ptr;
      if (fifo_pop)  rd_ptr <= ~rd_ptr;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  logic in_wait;
  logic timeout;

  assign in_wait = (state == S_WAIT) || (state == S_CAP2);

`ifdef ALU_TIMEOUT_EN
  logic [5:0] tcount;
  logic       err_q;

  // tcount is 0 in the first WAIT cycle and advances once per waiting cycle.
  // Expiry fires in the cycle where it holds 62, so the counter reaches 63
  // on the same edge that moves the FSM into RESP.
  assign timeout = in_wait && !alu_finish && (tcount == 6'd62);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tcount <= 6'd0;
    end else if (state == S_ISSUE_Y) begin
      tcount <= 6'd0;
    end else if (in_wait) begin
      tcount <= tcount + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end else if (fifo_pop) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_next;
  end

  logic [1:0] op_q;
  logic [7:0] x_q, y_q, hi_q;
  logic [15:0] data_q;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!fifo_empty) state_next = S_ISSUE_X;
      S_ISSUE_X: state_next = S_ISSUE_Y;
      S_ISSUE_Y: state_next = S_WAIT;
      S_WAIT: begin
        if (alu_finish)   state_next = op_q[1] ? S_CAP2 : S_RESP;
        else if (timeout) state_next = S_RESP;
      end
      S_CAP2:    if (alu_finish || timeout) state_next = S_RESP;
      S_RESP:    if (rsp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operands latched on pop, result bytes assembled on finish.
  // op_q doubles as alu_s so the opcode stays put after the operation ends.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q   <= 2'b00;
      x_q    <= 8'h00;
      y_q    <= 8'h00;
      hi_q   <= 8'h00;
      data_q <= 16'h0000;
    end else begin
      if (fifo_pop) begin
        op_q <= fifo_head[17:16];
        x_q  <= fifo_head[15:8];
        y_q  <= fifo_head[7:0];
      end
      if (state == S_WAIT && alu_finish) begin
        if (op_q[1]) hi_q   <= alu_outbus;
        else         data_q <= {8'h00, alu_outbus};
      end
      if (state == S_CAP2 && alu_finish) data_q <= {hi_q, alu_outbus};
      if (timeout) data_q <= 16'h0000;
    end
  end

  always_comb begin
    alu_inbus = 8'h00;
    case (state)
      S_ISSUE_X: alu_inbus = x_q;
      S_ISSUE_Y: alu_inbus = y_q;
      default:   alu_inbus = 8'h00;
    endcase
  end

  assign alu_start = (state == S_ISSUE_X);
  assign alu_s     = op_q;
  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_op    = op_q;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_host_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_host_seq
//
// Bench for alu_host_seq: a behavioural ALU responder, a response monitor with
// an expected queue, a directed vector table, hand-written multi-cycle
// sequences (queue full, response back-pressure, reset mid-operation, and the
// watchdog when ALU_TIMEOUT_EN is defined) and a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_host_seq;

  logic        clk;
  logic        rst_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        alu_start;
  logic [1:0]  alu_s;
  logic [7:0]  alu_inbus;
  logic        alu_finish;
  logic [7:0]  alu_outbus;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_op;
  logic        rsp_err;
  logic        busy;
  logic [2:0]  fsm_state;

  alu_host_seq dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .alu_start  (alu_start),
    .alu_s      (alu_s),
    .alu_inbus  (alu_inbus),
    .alu_finish (alu_finish),
    .alu_outbus (alu_outbus),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

  // ---------------------------------------------------------------------------
  // Shared state
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad = 0;
  int rsp_count = 0;
  logic [18:0] exp_q[$];     // {err, op, data}
  logic [7:0]  last_x, last_y;
  int          fix_delay = -1;   // <0: random ALU latency
  logic        noise_en = 1'b0;
  logic        hang = 1'b0;
  logic        rand_ready = 1'b0;
  logic        ready_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic for each opcode.
  function automatic logic [15:0] calc(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r;
    case (op)
      2'd0:    r = {8'h00, 8'(x + y)};
      2'd1:    r = {8'h00, 8'(x - y)};
      2'd2:    r = 16'(x) * 16'(y);
      default: r = (y == 8'h00) ? {x, 8'hFF} : {8'(x % y), 8'(x / y)};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_idle();
    cmd_valid = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  // with cmd_valid still asserted so commands can go back-to-back.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] d, input logic err);
    int n;
    logic acc;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 500) begin
      @(negedge clk);
      // A full FIFO still accepts while the idle FSM pops an entry.
      if (cmd_ready || fsm_state == 3'd0) begin
        acc = 1'b1;
        exp_q.push_back({err, op, d});
      end
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL cmd_accept: got no accept in %0d cycles want accept", n);
    end
    sync();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL wait_idle: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    sync();
  endtask

  task automatic wait_start(input int budget, output logic seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (alu_start) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_start: got no start want start");
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_alu_start"}, 32'(alu_start), 32'd0);
    check({tag, "_alu_s"},     32'(alu_s),     32'd0);
    check({tag, "_alu_inbus"}, 32'(alu_inbus), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, "_rsp_op"},    32'(rsp_op),    32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // rsp_ready driver
  // ---------------------------------------------------------------------------
  initial begin : ready_drv
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_force;
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural ALU: sees x with the start pulse, y the cycle after, then
  // returns one byte (add/sub) or two bytes high-first (mul/div) after a
  // latency. Between operations it may strobe alu_finish with junk, which the
  // sequencer must ignore.
  // ---------------------------------------------------------------------------
  initial begin : alu_model
    int phase, cnt, gap;
    logic [1:0]  ms;
    logic [7:0]  mx, my, b0, b1;
    logic [15:0] r;
    logic        two, just_fin;
    phase = 0; cnt = 0; gap = 0; two = 1'b0; just_fin = 1'b0;
    ms = 2'b00; mx = 8'h00; my = 8'h00; b0 = 8'h00; b1 = 8'h00;
    alu_finish = 1'b0;
    alu_outbus = 8'h00;
    forever begin
      @(negedge clk);
      alu_finish = 1'b0;
      alu_outbus = 8'h00;
      if (!rst_b) begin
        phase = 0;
        just_fin = 1'b0;
      end else begin
        case (phase)
          0: begin
            if (just_fin) begin
              check("rsp_latency", 32'(rsp_valid), 32'd1);
              just_fin = 1'b0;
            end
            if (alu_start && !hang) begin
              mx = alu_inbus;
              ms = alu_s;
              phase = 1;
            end else if (noise_en && !hang && $urandom_range(0, 3) == 0) begin
              alu_finish = 1'b1;
              alu_outbus = 8'($urandom_range(0, 255));
            end
          end
          1: begin
            check("start_pulse_width", 32'(alu_start), 32'd0);
            check("alu_s_issue_y", 32'(alu_s), 32'(ms));
            my = alu_inbus;
            last_x = mx;
            last_y = my;
            r = calc(ms, mx, my);
            two = ms[1];
            b0 = two ? r[15:8] : r[7:0];
            b1 = r[7:0];
            cnt = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 4);
            gap = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 3);
            phase = 2;
          end
          default: begin
            check("alu_s_hold", 32'(alu_s), 32'(ms));
            check("inbus_zero", 32'(alu_inbus), 32'd0);
            if (cnt == 0) begin
              alu_finish = 1'b1;
              alu_outbus = (phase == 2) ? b0 : b1;
              if (phase == 2 && two) begin
                phase = 3;
                cnt = gap;
              end else begin
                phase = 0;
                just_fin = 1'b1;
              end
            end else begin
              cnt--;
              alu_outbus = 8'($urandom_range(0, 255));
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: responses checked in order, held outputs checked for stability
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic        held;
    logic [15:0] held_data;
    logic [1:0]  held_op;
    logic        held_err;
    logic [18:0] e;
    held = 1'b0; held_data = 16'h0; held_op = 2'b0; held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          check("rsp_hold_data",  32'(rsp_data),  32'(held_data));
          check("rsp_hold_op",    32'(rsp_op),    32'(held_op));
          check("rsp_hold_err",   32'(rsp_err),   32'(held_err));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got %0h want none", rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
            check("rsp_op",   32'(rsp_op),   32'(e[17:16]));
            check("rsp_err",  32'(rsp_err),  32'(e[18]));
          end
          rsp_count++;
          held = 1'b0;
        end else if (rsp_valid) begin
          held = 1'b1;
          held_data = rsp_data;
          held_op = rsp_op;
          held_err = rsp_err;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  op;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    logic seen;
    logic [1:0] op;
    logic [7:0] x, y;
    logic [15:0] d0;
    int rc, k;

    vecs[0] = '{2'd0, 8'h12, 8'h05, 16'h0017};
    vecs[1] = '{2'd1, 8'h10, 8'h03, 16'h000D};
    vecs[2] = '{2'd1, 8'h00, 8'h01, 16'h00FF};
    vecs[3] = '{2'd0, 8'hFF, 8'h01, 16'h0000};
    vecs[4] = '{2'd2, 8'h0F, 8'h0F, 16'h00E1};
    vecs[5] = '{2'd2, 8'hFF, 8'hFF, 16'hFE01};
    vecs[6] = '{2'd3, 8'h64, 8'h07, 16'h020E};
    vecs[7] = '{2'd3, 8'h05, 8'h09, 16'h0500};
    vecs[8] = '{2'd2, 8'h10, 8'h20, 16'h0200};

    rst_b = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_x = 8'h00;
    cmd_y = 8'h00;
    last_x = 8'h00;
    last_y = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("por");
    rst_b = 1'b1;
    sync();

    // Directed vectors with junk strobes between operations.
    noise_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].exp, 1'b0);
      cmd_idle();
      wait_idle(300);
      check("vec_inbus_x", 32'(last_x), 32'(vecs[i].x));
      check("vec_inbus_y", 32'(last_y), 32'(vecs[i].y));
      check("alu_s_retain", 32'(alu_s), 32'(vecs[i].op));
    end

    // Queue fills while the first command executes; the fourth is only taken
    // once the first response has gone and the FSM pops again.
    noise_en = 1'b0;
    fix_delay = 8;
    send_cmd(2'd0, 8'h01, 8'h02, 16'h0003, 1'b0);
    send_cmd(2'd1, 8'h09, 8'h04, 16'h0005, 1'b0);
    send_cmd(2'd2, 8'h03, 8'h05, 16'h000F, 1'b0);
    cmd_idle();
    rc = rsp_count;
    @(negedge clk);
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    sync();
    send_cmd(2'd3, 8'h11, 8'h04, 16'h0104, 1'b0);
    cmd_idle();
    check("fourth_after_first_rsp", 32'(rsp_count > rc), 32'd1);
    wait_idle(500);
    check("in_order_count", 32'(rsp_count - rc), 32'd4);

    // Response back-pressure: outputs held, no new start issued.
    fix_delay = 1;
    ready_force = 1'b0;
    sync();
    sync();
    send_cmd(2'd0, 8'h40, 8'h02, 16'h0042, 1'b0);
    send_cmd(2'd1, 8'h40, 8'h02, 16'h003E, 1'b0);
    cmd_idle();
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    d0 = rsp_data;
    check("bp_first_data", 32'(d0), 32'h0042);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_data_hold", 32'(rsp_data), 32'(d0));
      check("bp_no_start", 32'(alu_start), 32'd0);
    end
    sync();
    ready_force = 1'b1;
    wait_idle(300);

    // Reset while waiting for the ALU: immediate reset values, no response.
    fix_delay = 30;
    send_cmd(2'd2, 8'h33, 8'h44, calc(2'd2, 8'h33, 8'h44), 1'b0);
    cmd_idle();
    wait_start(50, seen);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    check_reset_outs("mid_wait");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("reset_no_rsp", 32'(rsp_valid), 32'd0);
    sync();
    rst_b = 1'b1;
    fix_delay = -1;
    sync();
    rc = rsp_count;
    send_cmd(2'd0, 8'h20, 8'h22, 16'h0042, 1'b0);
    cmd_idle();
    wait_idle(200);
    check("post_reset_rsp", 32'(rsp_count - rc), 32'd1);

`ifdef ALU_TIMEOUT_EN
    // Watchdog: divide with the ALU never answering.
    hang = 1'b1;
    send_cmd(2'd3, 8'h40, 8'h02, 16'h0000, 1'b1);
    cmd_idle();
    wait_start(50, seen);
    @(negedge clk);
    @(negedge clk);
    k = 0;
    while (!rsp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", 32'(k), 32'd63);
    wait_idle(100);
    hang = 1'b0;
`endif

    // Randomized traffic with random back-pressure and latencies.
    noise_en = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = 8'($urandom_range(0, 255));
      y  = 8'($urandom_range(0, 255));
      if (op == 2'd3 && y == 8'h00) y = 8'h01;
      send_cmd(op, x, y, calc(op, x, y), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        cmd_idle();
        repeat ($urandom_range(1, 4)) sync();
      end
    end
    cmd_idle();
    rand_ready = 1'b0;
    ready_force = 1'b1;
    wait_idle(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
